// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WR write ports, NUM_RD registered read ports, same-cycle bypass and stall hold.
// Optional per-register busy scoreboard when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WR-1:0]                regf_we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]    rd_s,
    input  logic [NUM_WR-1:0][DATA_W-1:0]    rd_v,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]    rs_s,
    input  logic                             stall,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rs_v
`ifdef REGFILE_SCOREBOARD_EN
    ,
    input  logic                             alloc_en,
    input  logic [ADDR_W-1:0]                alloc_s,
    output logic [NUM_RD-1:0]                rs_busy
`endif
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NUM_RD-1:0][DATA_W-1:0]   rs_v_q, rs_v_d;

    // Ascending port order lets the highest-index port overwrite lower ones on collision;
    // reads then index the post-write image, which yields the bypass for free.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (regf_we[w] && (rd_s[w] != '0)) begin
                mem_d[rd_s[w]] = rd_v[w];
            end
        end
        mem_d[0] = '0;

        rs_v_d = rs_v_q;
        if (!stall) begin
            for (int r = 0; r < NUM_RD; r++) begin
                rs_v_d[r] = mem_d[rs_s[r]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            rs_v_q <= '0;
        end else begin
            mem_q  <= mem_d;
            rs_v_q <= rs_v_d;
        end
    end

    assign rs_v = rs_v_q;

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_RD-1:0]   rs_busy_q, rs_busy_d;

    // Clears are applied before the set so an allocation in the same cycle as a write keeps the bit.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (regf_we[w] && (rd_s[w] != '0)) begin
                busy_d[rd_s[w]] = 1'b0;
            end
        end
        if (alloc_en && (alloc_s != '0)) begin
            busy_d[alloc_s] = 1'b1;
        end
        busy_d[0] = 1'b0;

        rs_busy_d = rs_busy_q;
        if (!stall) begin
            for (int r = 0; r < NUM_RD; r++) begin
                rs_busy_d[r] = busy_d[rs_s[r]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            rs_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rs_busy_q <= rs_busy_d;
        end
    end

    assign rs_busy = rs_busy_q;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: driver queues hand-computed expectations, monitor checks after each edge.
// Busy checks are compiled in when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_WR-1:0]             regf_we;
    logic [NUM_WR-1:0][ADDR_W-1:0] rd_s;
    logic [NUM_WR-1:0][DATA_W-1:0] rd_v;
    logic [NUM_RD-1:0][ADDR_W-1:0] rs_s;
    logic                          stall;
    logic [NUM_RD-1:0][DATA_W-1:0] rs_v;
`ifdef REGFILE_SCOREBOARD_EN
    logic                          alloc_en;
    logic [ADDR_W-1:0]             alloc_s;
    logic [NUM_RD-1:0]             rs_busy;
`endif

    regfile_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk(clk), .rst(rst), .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v),
        .rs_s(rs_s), .stall(stall), .rs_v(rs_v)
`ifdef REGFILE_SCOREBOARD_EN
        , .alloc_en(alloc_en), .alloc_s(alloc_s), .rs_busy(rs_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_busy;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   exp_n = 0;
    int   tests = 0;
    int   fails = 0;

    // Monitor: takes the expectation count issued for this edge, checks 1 time unit later.
    always @(posedge clk) begin
        int   n;
        exp_t e;
        n = exp_n;
        #1;
        for (int k = 0; k < n; k++) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: no expectation queued");
            end else begin
                e = sb_q.pop_front();
                if (!e.is_busy) begin
                    if (rs_v[e.port] !== e.val) begin
                        fails++;
                        $display("FAIL %s: rs_v[%0d] got 0x%08h expected 0x%08h",
                                 e.name, e.port, rs_v[e.port], e.val);
                    end
                end else begin
`ifdef REGFILE_SCOREBOARD_EN
                    if (rs_busy[e.port] !== e.val[0]) begin
                        fails++;
                        $display("FAIL %s: rs_busy[%0d] got %b expected %b",
                                 e.name, e.port, rs_busy[e.port], e.val[0]);
                    end
`endif
                end
            end
        end
    end

    task automatic begin_cycle();
        @(negedge clk);
        rst     = 1'b0;
        regf_we = '0;
        rd_s    = '0;
        rd_v    = '0;
        rs_s    = '0;
        stall   = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
        alloc_en = 1'b0;
        alloc_s  = '0;
`endif
        exp_n   = 0;
    endtask

    task automatic exp_rd(input string nm, input int p, input logic [31:0] v);
        exp_t e;
        e.name = nm; e.is_busy = 1'b0; e.port = p; e.val = v;
        sb_q.push_back(e);
        exp_n++;
    endtask

    task automatic exp_busy(input string nm, input int p, input logic b);
        exp_t e;
        e.name = nm; e.is_busy = 1'b1; e.port = p; e.val = {31'b0, b};
        sb_q.push_back(e);
        exp_n++;
    endtask

    task automatic wr(input int p, input int idx, input logic [31:0] v);
        regf_we[p] = 1'b1;
        rd_s[p]    = ADDR_W'(idx);
        rd_v[p]    = v;
    endtask

    initial begin
        rst = 1'b1; regf_we = '0; rd_s = '0; rd_v = '0; rs_s = '0; stall = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
        alloc_en = 1'b0; alloc_s = '0;
`endif
        // Reset
        begin_cycle(); rst = 1'b1; rs_s[0] = 5'd4; rs_s[1] = 5'd9;
        exp_rd("reset_p0", 0, 32'h0); exp_rd("reset_p1", 1, 32'h0);
        for (int i = 0; i < NUM_REGS; i++) begin
            begin_cycle(); rs_s[0] = ADDR_W'(i); rs_s[1] = ADDR_W'(NUM_REGS - 1 - i);
            exp_rd("post_reset_p0", 0, 32'h0); exp_rd("post_reset_p1", 1, 32'h0);
        end

        // Basic write then read; x0 discards writes
        begin_cycle(); wr(0, 5, 32'hDEADBEEF);
        begin_cycle(); wr(0, 0, 32'h00001234); rs_s[0] = 5'd5; rs_s[1] = 5'd0;
        exp_rd("read_x5", 0, 32'hDEADBEEF); exp_rd("x0_bypass_zero", 1, 32'h0);
        begin_cycle(); rs_s[1] = 5'd0;
        exp_rd("read_x0", 1, 32'h0);

        // Same-cycle bypass
        begin_cycle(); wr(0, 7, 32'hA5A5A5A5); rs_s[1] = 5'd7; rs_s[0] = 5'd5;
        exp_rd("bypass_x7", 1, 32'hA5A5A5A5); exp_rd("read_x5_again", 0, 32'hDEADBEEF);

        // Collision: port 1 wins for data and for bypass
        begin_cycle(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); rs_s[0] = 5'd3;
        exp_rd("collision_bypass", 0, 32'h22);
        begin_cycle(); rs_s[1] = 5'd3;
        exp_rd("collision_array", 1, 32'h22);

        // Two ports, distinct targets, same cycle
        begin_cycle(); wr(0, 10, 32'h0000AAAA); wr(1, 11, 32'h0000BBBB);
        rs_s[0] = 5'd11; rs_s[1] = 5'd10;
        exp_rd("dual_bypass_p0", 0, 32'h0000BBBB); exp_rd("dual_bypass_p1", 1, 32'h0000AAAA);
        begin_cycle(); rs_s[0] = 5'd10; rs_s[1] = 5'd11;
        exp_rd("dual_array_p0", 0, 32'h0000AAAA); exp_rd("dual_array_p1", 1, 32'h0000BBBB);

        // Stall hold while x3 is rewritten
        begin_cycle(); wr(1, 3, 32'h11); rs_s[0] = 5'd3; rs_s[1] = 5'd7;
        exp_rd("pre_stall_p0", 0, 32'h11); exp_rd("pre_stall_p1", 1, 32'hA5A5A5A5);
        begin_cycle(); stall = 1'b1; wr(0, 3, 32'h33); rs_s[0] = 5'd3; rs_s[1] = 5'd5;
        exp_rd("stall_hold_p0", 0, 32'h11); exp_rd("stall_hold_p1", 1, 32'hA5A5A5A5);
        for (int i = 0; i < 2; i++) begin
            begin_cycle(); stall = 1'b1; rs_s[0] = 5'd3; rs_s[1] = 5'd10;
            exp_rd("stall_hold_p0", 0, 32'h11); exp_rd("stall_hold_p1", 1, 32'hA5A5A5A5);
        end
        begin_cycle(); rs_s[0] = 5'd3; rs_s[1] = 5'd7; wr(1, 7, 32'h77);
        exp_rd("stall_release", 0, 32'h33); exp_rd("stall_release_bypass", 1, 32'h77);

        // Reset mid-operation overrides stall and writes
        begin_cycle(); rst = 1'b1; stall = 1'b1; wr(0, 12, 32'hFF); rs_s[0] = 5'd5; rs_s[1] = 5'd12;
        exp_rd("midreset_p0", 0, 32'h0); exp_rd("midreset_p1", 1, 32'h0);
        begin_cycle(); rs_s[0] = 5'd5; rs_s[1] = 5'd12;
        exp_rd("midreset_cleared", 0, 32'h0); exp_rd("midreset_write_lost", 1, 32'h0);

`ifdef REGFILE_SCOREBOARD_EN
        begin_cycle(); alloc_en = 1'b1; alloc_s = 5'd9; rs_s[0] = 5'd9; rs_s[1] = 5'd8;
        exp_busy("alloc_x9", 0, 1'b1); exp_busy("x8_idle", 1, 1'b0);
        begin_cycle(); alloc_en = 1'b1; alloc_s = 5'd9; wr(0, 9, 32'h99); rs_s[0] = 5'd9;
        exp_busy("alloc_wins", 0, 1'b1); exp_rd("alloc_write_data", 0, 32'h99);
        begin_cycle(); wr(1, 9, 32'h100); rs_s[1] = 5'd9;
        exp_busy("write_clears", 1, 1'b0); exp_rd("clear_write_data", 1, 32'h100);
        begin_cycle(); rs_s[0] = 5'd9;
        exp_busy("still_clear", 0, 1'b0);
        begin_cycle(); alloc_en = 1'b1; alloc_s = 5'd0; rs_s[0] = 5'd0;
        exp_busy("busy_x0_zero", 0, 1'b0);
        begin_cycle(); alloc_en = 1'b1; alloc_s = 5'd9; rs_s[1] = 5'd9;
        exp_busy("realloc_x9", 1, 1'b1);
        begin_cycle(); stall = 1'b1; wr(0, 9, 32'h5); rs_s[1] = 5'd9;
        exp_busy("busy_stall_hold", 1, 1'b1);
        begin_cycle(); alloc_en = 1'b1; alloc_s = 5'd9; rs_s[0] = 5'd9;
        exp_busy("realloc_again", 0, 1'b1);
        begin_cycle(); rst = 1'b1; rs_s[0] = 5'd9;
        exp_busy("reset_busy_out", 0, 1'b0);
        begin_cycle(); rs_s[0] = 5'd9;
        exp_busy("reset_busy_state", 0, 1'b0);
`endif

        begin_cycle();
        begin_cycle();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
